// File: rtl/vga_ctr_display_if.sv
// Iteration-count stream from the mandelbrot engine into the VGA display stage.
// The engine drives valid/ctr; the display answers with ready when its FIFO has room.
interface vga_ctr_display_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_ctr;

  modport master (output in_valid, output in_ctr, input in_ready);
  modport slave  (input in_valid, input in_ctr, output in_ready);
endinterface

// File: rtl/vga_ctr_display.sv
// VGA display stage: buffers engine iteration counts in a small FIFO and paints each
// count as a PIXEL_REPEAT-wide block through a fixed palette, with raster timing,
// a frame-start pulse for the engine and a sticky FIFO underflow flag.
// PIXEL_REPEAT and FIFO_DEPTH must be powers of two (FIFO_DEPTH >= 2).
module vga_ctr_display #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int PIXEL_REPEAT = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic             clk,
  input  logic             reset,
  vga_ctr_display_if.slave in_bus,
  output logic [1:0]       R,
  output logic [1:0]       G,
  output logic [1:0]       B,
  output logic             hsync,
  output logic             vsync,
  output logic             frame_start,
  output logic             underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [HW-1:0] REP_MASK = HW'(PIXEL_REPEAT - 1);

  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  logic          h_last;
  logic          v_last;
  logic          active;
  logic          at_origin;
  logic          pop_req;

  logic [3:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  logic [3:0]    pix;
  logic [3:0]    pix_next;
  logic [5:0]    rgb_next;

  assign h_last    = (h_cnt == HW'(H_TOTAL - 1));
  assign v_last    = (v_cnt == VW'(V_TOTAL - 1));
  assign active    = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign pop_req   = active && ((h_cnt & REP_MASK) == '0);

  assign full            = (count == CW'(FIFO_DEPTH));
  assign empty           = (count == '0);
  assign in_bus.in_ready = !full;
  assign push            = in_bus.in_valid && !full;
  assign pop             = pop_req && !empty;

  // Raster position: h wraps every line, v advances on each h wrap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // FIFO storage needs no reset; emptiness is tracked by the count
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_bus.in_ctr;
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Value shown for the current pixel: fresh FIFO head at a group start, black on underflow
  always_comb begin
    pix_next = pix;
    if (pop)          pix_next = mem[rd_ptr];
    else if (pop_req) pix_next = 4'hF;
  end

  // Palette lookup; 0xF is the in-set colour (black) and blanking is always black
  always_comb begin
    rgb_next = '0;
    if (active && (pix_next != 4'hF))
      rgb_next = {pix_next[3], pix_next[2], pix_next[2], pix_next[1], pix_next[1], pix_next[0]};
  end

  // Registered outputs, one cycle behind the raster counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix         <= 4'hF;
      R           <= '0;
      G           <= '0;
      B           <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      pix         <= pix_next;
      R           <= rgb_next[5:4];
      G           <= rgb_next[3:2];
      B           <= rgb_next[1:0];
      hsync       <= !((h_cnt >= HW'(H_ACTIVE + H_FRONT)) &&
                       (h_cnt <  HW'(H_ACTIVE + H_FRONT + H_SYNC)));
      vsync       <= !((v_cnt >= VW'(V_ACTIVE + V_FRONT)) &&
                       (v_cnt <  VW'(V_ACTIVE + V_FRONT + V_SYNC)));
      frame_start <= at_origin;
      underflow   <= (pop_req && empty) ? 1'b1 : (at_origin ? 1'b0 : underflow);
    end
  end

endmodule

// File: tb/tb_vga_ctr_display.sv
// Testbench for vga_ctr_display using a reduced raster so several frames fit in a short run.
// A queue holds values accepted by the FIFO; they are popped as the display consumes them.
module tb_vga_ctr_display;

  localparam int HA = 64, HF = 8, HS = 16, HB = 8;
  localparam int HT = HA + HF + HS + HB;
  localparam int VA = 20, VF = 2, VS = 2, VB = 3;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int REP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] R, G, B;
  logic       hsync, vsync, frame_start, underflow;

  vga_ctr_display_if bus();

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  logic [3:0] exp_q[$];
  logic [3:0] exp_pix = 4'hF;
  logic [5:0] exp_rgb = 6'd0;
  logic       exp_hs = 1'b1, exp_vs = 1'b1, exp_fs = 1'b0, exp_uf = 1'b0;
  logic       pend_valid = 1'b0;
  logic [3:0] pend_val = 4'h0;

  vga_ctr_display #(
    .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .PIXEL_REPEAT(REP), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .in_bus(bus),
    .R(R), .G(G), .B(B),
    .hsync(hsync), .vsync(vsync), .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; the raster position follows from it
  always @(posedge clk or posedge reset) begin
    if (reset) edge_cnt <= 0;
    else       edge_cnt <= edge_cnt + 1;
  end

  function automatic int cur_pos();
    return edge_cnt % FRAME;
  endfunction

  function automatic int prev_pos();
    return (edge_cnt + FRAME - 1) % FRAME;
  endfunction

  function automatic logic [5:0] palette(input logic [3:0] p);
    return (p == 4'hF) ? 6'd0 : {p[3], p[2], p[2], p[1], p[1], p[0]};
  endfunction

  // One clock: update expected outputs for the raster state just displayed, then commit the push
  task automatic advance();
    int p, ph, pv;
    logic act, set_uf;
    @(posedge clk); #1;
    p = prev_pos(); ph = p % HT; pv = p / HT;
    act = (ph < HA) && (pv < VA);
    set_uf = 1'b0;
    if (act && (ph % REP == 0)) begin
      if (exp_q.size() > 0) exp_pix = exp_q.pop_front();
      else begin exp_pix = 4'hF; set_uf = 1'b1; end
    end
    if (set_uf) exp_uf = 1'b1;
    else if (p == 0) exp_uf = 1'b0;
    exp_rgb = act ? palette(exp_pix) : 6'd0;
    exp_fs  = (p == 0);
    exp_hs  = !((ph >= HA + HF) && (ph < HA + HF + HS));
    exp_vs  = !((pv >= VA + VF) && (pv < VA + VF + VS));
    if (pend_valid) begin exp_q.push_back(pend_val); pend_valid = 1'b0; end
  endtask

  task automatic drive(input logic v, input logic [3:0] c);
    bus.in_valid = v;
    bus.in_ctr   = c;
    if (v && bus.in_ready) begin pend_valid = 1'b1; pend_val = c; end
  endtask

  // Reset values while reset is held
  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_ctr = 4'h0; reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({R, G, B} !== 6'd0) begin errors++; $display("[TB] FAIL reset_rgb got %b exp 000000", {R, G, B}); end
    checks++; if (hsync !== 1'b1) begin errors++; $display("[TB] FAIL reset_hsync got %b exp 1", hsync); end
    checks++; if (vsync !== 1'b1) begin errors++; $display("[TB] FAIL reset_vsync got %b exp 1", vsync); end
    checks++; if (frame_start !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_start got %b exp 0", frame_start); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_underflow got %b exp 0", underflow); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b exp 1", bus.in_ready); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // One full frame with no input: sync pulse placement, frame_start spacing, underflow
  task automatic test_frame_timing();
    int fs1 = -1, fs2 = -1, hs_first = -1, hs_low = 0, vs_first = -1, vs_low = 0;
    int uf_bad = 0, rgb_bad = 0;
    for (int k = 1; k <= FRAME + 1; k++) begin
      advance();
      if (frame_start === 1'b1) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (hsync === 1'b0 && k <= HT) begin hs_low++; if (hs_first < 0) hs_first = k; end
      if (vsync === 1'b0) begin vs_low++; if (vs_first < 0) vs_first = k; end
      if (underflow !== 1'b1) uf_bad++;
      if ({R, G, B} !== 6'd0) rgb_bad++;
    end
    checks++; if (fs1 != 1) begin errors++; $display("[TB] FAIL first_frame_start got %0d exp 1", fs1); end
    checks++; if (fs2 != FRAME + 1) begin errors++; $display("[TB] FAIL next_frame_start got %0d exp %0d", fs2, FRAME + 1); end
    checks++; if (hs_first != HA + HF + 1) begin errors++; $display("[TB] FAIL hsync_fall got %0d exp %0d", hs_first, HA + HF + 1); end
    checks++; if (hs_low != HS) begin errors++; $display("[TB] FAIL hsync_width got %0d exp %0d", hs_low, HS); end
    checks++; if (vs_first != (VA + VF) * HT + 1) begin errors++; $display("[TB] FAIL vsync_fall got %0d exp %0d", vs_first, (VA + VF) * HT + 1); end
    checks++; if (vs_low != VS * HT) begin errors++; $display("[TB] FAIL vsync_width got %0d exp %0d", vs_low, VS * HT); end
    checks++; if (uf_bad != 0) begin errors++; $display("[TB] FAIL empty_underflow cycles_low got %0d exp 0", uf_bad); end
    checks++; if (rgb_bad != 0) begin errors++; $display("[TB] FAIL empty_black cycles_lit got %0d exp 0", rgb_bad); end
  endtask

  // Hold in_valid in vertical blanking: 8 accepted, 9th waits for the first pop
  task automatic test_fill();
    int acc = 0, guard = 0;
    logic got9 = 1'b0;
    logic [9:0] obs, expv;
    while (cur_pos() != VA * HT && guard < FRAME) begin drive(1'b0, 4'h0); advance(); guard++; end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, (acc < 8) ? 4'(acc + 1) : 4'hC);
      if (pend_valid) acc++;
      advance();
    end
    checks++; if (acc != 8) begin errors++; $display("[TB] FAIL fill_accepted got %0d exp 8", acc); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fill_in_ready got %b exp 0", bus.in_ready); end
    guard = 0;
    while (!got9 && guard < FRAME) begin
      drive(1'b1, 4'hC);
      if (pend_valid) got9 = 1'b1;
      advance(); guard++;
    end
    drive(1'b0, 4'h0);
    checks++; if (got9 !== 1'b1 || prev_pos() != 1) begin errors++; $display("[TB] FAIL ninth_accept got pos %0d exp 1", prev_pos()); end
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL refill_in_ready got %b exp 0", bus.in_ready); end
    guard = 0;
    while (prev_pos() != HA + 4 && guard < FRAME) begin
      advance(); guard++;
      obs  = {R, G, B, hsync, vsync, frame_start, underflow};
      expv = {exp_rgb, exp_hs, exp_vs, exp_fs, exp_uf};
      checks++; if (obs !== expv) begin errors++; $display("[TB] FAIL fill_scoreboard pos %0d got %b exp %b", prev_pos(), obs, expv); end
      if (prev_pos() == 28) begin
        checks++; if ({R, G, B} !== 6'b100000) begin errors++; $display("[TB] FAIL fill_pixel28 got %b exp 100000", {R, G, B}); end
      end
      if (prev_pos() == 32) begin
        checks++; if ({R, G, B} !== 6'b111000) begin errors++; $display("[TB] FAIL fill_pixel32 got %b exp 111000", {R, G, B}); end
      end
      if (prev_pos() == 36) begin
        checks++; if ({R, G, B, underflow} !== 7'b0000001) begin errors++; $display("[TB] FAIL fill_pixel36 got %b exp 0000001", {R, G, B, underflow}); end
      end
    end
  endtask

  // Push 0x0, 0x5, 0xA, 0xF in blanking and check the first groups of the next frame
  task automatic test_palette();
    int guard = 0;
    logic [3:0] vals [4];
    logic [9:0] obs, expv;
    vals[0] = 4'h0; vals[1] = 4'h5; vals[2] = 4'hA; vals[3] = 4'hF;
    while (cur_pos() != VA * HT && guard < FRAME) begin drive(1'b0, 4'h0); advance(); guard++; end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i]);
      checks++; if (pend_valid !== 1'b1) begin errors++; $display("[TB] FAIL palette_push%0d in_ready got 0 exp 1", i); end
      advance();
    end
    drive(1'b0, 4'h0);
    guard = 0;
    while (prev_pos() != HA + 1 && guard < FRAME) begin
      advance(); guard++;
      obs  = {R, G, B, hsync, vsync, frame_start, underflow};
      expv = {exp_rgb, exp_hs, exp_vs, exp_fs, exp_uf};
      checks++; if (obs !== expv) begin errors++; $display("[TB] FAIL palette_scoreboard pos %0d got %b exp %b", prev_pos(), obs, expv); end
      case (prev_pos())
        1: begin checks++; if ({R, G, B} !== 6'b000000) begin errors++; $display("[TB] FAIL palette_0 got %b exp 000000", {R, G, B}); end end
        5: begin checks++; if ({R, G, B} !== 6'b011001) begin errors++; $display("[TB] FAIL palette_5 got %b exp 011001", {R, G, B}); end end
        9: begin checks++; if ({R, G, B} !== 6'b100110) begin errors++; $display("[TB] FAIL palette_A got %b exp 100110", {R, G, B}); end end
        13: begin checks++; if ({R, G, B, underflow} !== 7'b0000000) begin errors++; $display("[TB] FAIL palette_F got %b exp 0000000", {R, G, B, underflow}); end end
        17: begin checks++; if ({R, G, B, underflow} !== 7'b0000001) begin errors++; $display("[TB] FAIL palette_underflow got %b exp 0000001", {R, G, B, underflow}); end end
        default: ;
      endcase
    end
  endtask

  // Prefill 4 entries, then push exactly when the display pops so occupancy never moves
  task automatic test_back_to_back();
    int guard = 0, fs_seen = 0, c;
    logic [9:0] obs, expv;
    while (cur_pos() != VA * HT && guard < FRAME) begin drive(1'b0, 4'h0); advance(); guard++; end
    for (int i = 0; i < 4; i++) begin drive(1'b1, 4'($urandom_range(0, 15))); advance(); end
    guard = 0;
    while (!(fs_seen == 2 && cur_pos() == 10 * HT + 30) && guard < 3 * FRAME) begin
      c = cur_pos();
      if ((c % HT) < HA && (c / HT) < VA && (c % HT) % REP == 0) drive(1'b1, 4'($urandom_range(0, 15)));
      else drive(1'b0, 4'h0);
      advance(); guard++;
      if (frame_start === 1'b1) fs_seen++;
      obs  = {R, G, B, hsync, vsync, frame_start, underflow};
      expv = {exp_rgb, exp_hs, exp_vs, exp_fs, exp_uf};
      checks++; if (obs !== expv) begin errors++; $display("[TB] FAIL b2b_scoreboard pos %0d got %b exp %b", prev_pos(), obs, expv); end
      if (fs_seen > 0) begin
        checks++; if (underflow !== 1'b0) begin errors++; $display("[TB] FAIL b2b_underflow pos %0d got 1 exp 0", prev_pos()); end
      end
    end
    checks++; if (guard >= 3 * FRAME) begin errors++; $display("[TB] FAIL b2b_timeout got %0d frame_starts exp 2", fs_seen); end
  endtask

  // Reset mid-line with entries queued: async clear, empty FIFO, fresh frame_start
  task automatic test_reset_mid();
    int guard = 0;
    logic [9:0] obs, expv;
    #2;
    reset = 1'b1;
    #1;
    checks++; if ({R, G, B} !== 6'd0) begin errors++; $display("[TB] FAIL mid_reset_rgb got %b exp 000000", {R, G, B}); end
    checks++; if ({hsync, vsync, frame_start, underflow} !== 4'b1100) begin errors++; $display("[TB] FAIL mid_reset_flags got %b exp 1100", {hsync, vsync, frame_start, underflow}); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_in_ready got %b exp 1", bus.in_ready); end
    bus.in_valid = 1'b0;
    exp_q.delete();
    exp_uf = 1'b0; exp_pix = 4'hF; pend_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    advance();
    checks++; if (frame_start !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_frame_start got %b exp 1", frame_start); end
    while (prev_pos() != HA && guard < FRAME) begin
      advance(); guard++;
      obs  = {R, G, B, hsync, vsync, frame_start, underflow};
      expv = {exp_rgb, exp_hs, exp_vs, exp_fs, exp_uf};
      checks++; if (obs !== expv) begin errors++; $display("[TB] FAIL mid_reset_scoreboard pos %0d got %b exp %b", prev_pos(), obs, expv); end
    end
    checks++; if ({R, G, B, underflow} !== 7'b0000001) begin errors++; $display("[TB] FAIL mid_reset_flushed got %b exp 0000001", {R, G, B, underflow}); end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_ctr   = 4'h0;
    test_reset();
    test_frame_timing();
    test_fill();
    test_palette();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
